// File: rtl/fir_sched_pkg.sv
// Shared types and defaults for the FIR channel scheduler.
// The bank-id width helper is used by every file of the block.
package fir_sched_pkg;

    localparam int NUM_CH_DEF  = 4;
    localparam int DATA_W_DEF  = 16;
    localparam int ACC_W_DEF   = 38;
    localparam int TIMEOUT_DEF = 80;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_W = ch_w(NUM_CH_DEF);

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        OUT
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first set request at or above the pointer.
// The pointer wraps naturally because N is a power of two.
module rr_arbiter
    import fir_sched_pkg::*;
#(
    parameter int N = NUM_CH_DEF,
    parameter int W = ch_w(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] rr_ptr_i,
    output logic [W-1:0] grant_o,
    output logic         any_req_o
);

    logic [W-1:0] idx;
    logic         found;

    always_comb begin
        idx     = '0;
        found   = 1'b0;
        grant_o = '0;
        for (int k = 0; k < N; k++) begin
            idx = rr_ptr_i + W'(k);
            if (!found && req_i[idx]) begin
                grant_o = idx;
                found   = 1'b1;
            end
        end
        any_req_o = found;
    end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Time-shares one FIR engine between NUM_CH sample channels.
// One transaction at a time: accept, start, wait for done, deliver.
module fir_channel_scheduler
    import fir_sched_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic                     eng_start,
    output logic [DATA_W-1:0]        eng_data,
    output logic [ch_w(NUM_CH)-1:0]  eng_bank,
    input  logic                     eng_done,
    input  logic [ACC_W-1:0]         eng_result,
    output logic                     out_valid,
    output logic [ACC_W-1:0]         out_data,
    output logic [ch_w(NUM_CH)-1:0]  out_ch,
    input  logic                     out_ready,
    output logic                     err_timeout
);

    localparam int CW = ch_w(NUM_CH);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e            state_q;
    logic [CW-1:0]     rr_ptr_q;
    logic [TW-1:0]     cnt_q;
    logic [DATA_W-1:0] eng_data_q;
    logic [CW-1:0]     eng_bank_q;
    logic              eng_start_q;
    logic              out_valid_q;
    logic [ACC_W-1:0]  out_data_q;
    logic [CW-1:0]     out_ch_q;
    logic              err_q;

    logic [CW-1:0]     grant;
    logic              any_req;
    logic [NUM_CH-1:0] ready_d;

    rr_arbiter #(
        .N(NUM_CH),
        .W(CW)
    ) u_arb (
        .req_i    (ch_valid),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (grant),
        .any_req_o(any_req)
    );

    // Acknowledge in the same IDLE cycle the sample is captured.
    always_comb begin
        ready_d = '0;
        if (!rst && state_q == IDLE && any_req) begin
            ready_d[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            eng_data_q  <= '0;
            eng_bank_q  <= '0;
            eng_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            eng_start_q <= 1'b0;
            err_q       <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        eng_data_q  <= ch_data[grant*DATA_W +: DATA_W];
                        eng_bank_q  <= grant;
                        rr_ptr_q    <= grant + 1'b1;
                        eng_start_q <= 1'b1;
                        state_q     <= START;
                    end
                end
                START: begin
                    cnt_q   <= '0;
                    state_q <= BUSY;
                end
                BUSY: begin
                    // A done on the final allowed cycle still counts.
                    if (eng_done) begin
                        out_data_q  <= eng_result;
                        out_ch_q    <= eng_bank_q;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ch_ready    = ready_d;
    assign eng_start   = eng_start_q;
    assign eng_data    = eng_data_q;
    assign eng_bank    = eng_bank_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_ch      = out_ch_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed/random bench for fir_channel_scheduler with an engine model
// and a transaction-level reference for grants, latency and results.
module tb_fir_channel_scheduler;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 38;
    localparam int TO = 80;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    ch_valid;
    logic [N*DW-1:0] ch_data;
    logic [N-1:0]    ch_ready;
    logic            eng_start;
    logic [DW-1:0]   eng_data;
    logic [1:0]      eng_bank;
    logic            eng_done;
    logic [AW-1:0]   eng_result;
    logic            out_valid;
    logic [AW-1:0]   out_data;
    logic [1:0]      out_ch;
    logic            out_ready;
    logic            err_timeout;

    logic [N-1:0] pend = '0;
    logic [N-1:0] cont = '0;
    assign ch_valid = pend | cont;

    fir_channel_scheduler #(
        .NUM_CH(N), .DATA_W(DW), .ACC_W(AW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
        .eng_start(eng_start), .eng_data(eng_data), .eng_bank(eng_bank),
        .eng_done(eng_done), .eng_result(eng_result),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Engine model: done pulse eng_delay cycles after start (0 = never).
    int          eng_delay = 5;
    int          pend_cnt = 0;
    logic [AW-1:0] cur_res = '0;
    logic [AW-1:0] res_fix = '0;
    bit          res_fix_en = 0;
    bit          stale_req = 0;

    initial begin
        eng_done = 1'b0;
        eng_result = '0;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (stale_req) begin
                eng_done = 1'b1;
                eng_result = 38'h3_ffff;
                stale_req = 0;
            end
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    eng_done = 1'b1;
                    eng_result = cur_res;
                end
            end
            if (eng_start === 1'b1 && eng_delay > 0) begin
                pend_cnt = eng_delay;
                cur_res = res_fix_en ? res_fix : AW'({$urandom, $urandom});
            end
        end
    end

    // Reference: round-robin from a pointer, one transaction in flight.
    int          mptr = 0;
    bit          inflight = 0;
    int          g_cyc = 0, s_cyc = 0, h_cyc = 0, s_delay = 0;
    int          exp_g = 0, e = 0, jj = 0;
    logic [DW-1:0] exp_d = '0;
    int          grants[$];
    int          out_rises = 0, err_pulses = 0, ready_pulses = 0;
    logic        prev_ov = 1'b0;
    logic [N-1:0] rdy_seen = '0;
    bit          chk_bubble = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            mptr = 0;
            inflight = 0;
            prev_ov = 1'b0;
        end else begin
            if (err_timeout) begin
                err_pulses++;
                chk("timeout_lat", 64'(cyc - (s_cyc + 1)), 64'(TO));
                inflight = 0;
            end
            if (ch_ready != '0) begin
                ready_pulses++;
                rdy_seen = ch_ready;
                e = -1;
                for (int k = 0; k < N; k++) begin
                    jj = (mptr + k) % N;
                    if (e < 0 && ch_valid[jj]) e = jj;
                end
                chk("grant_idle", 64'(inflight), 64'd0);
                chk("grant", 64'(ch_ready), (e >= 0) ? (64'd1 << e) : 64'd0);
                if (e >= 0) begin
                    exp_g = e;
                    exp_d = ch_data[e*DW +: DW];
                    mptr = (e + 1) % N;
                    grants.push_back(e);
                end
                if (chk_bubble) begin
                    chk("bubble", 64'(cyc - h_cyc), 64'd1);
                    chk_bubble = 0;
                end
                inflight = 1;
                g_cyc = cyc;
            end
            if (eng_start) begin
                s_cyc = cyc;
                s_delay = eng_delay;
                chk("start_lat", 64'(cyc - g_cyc), 64'd1);
                chk("eng_data", 64'(eng_data), 64'(exp_d));
                chk("eng_bank", 64'(eng_bank), 64'(exp_g));
            end
            if (out_valid && !prev_ov) begin
                out_rises++;
                chk("out_lat", 64'(cyc - s_cyc), 64'(s_delay + 1));
                chk("out_data", 64'(out_data), 64'(cur_res));
                chk("out_ch", 64'(out_ch), 64'(exp_g));
            end
            if (out_valid && out_ready) begin
                inflight = 0;
                h_cyc = cyc;
            end
            prev_ov = out_valid;
        end
    end

    // Requesters drop their pulse-request once they have seen ch_ready.
    initial forever begin
        @(posedge clk);
        #1;
        pend = pend & ~rdy_seen;
        rdy_seen = '0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int rp0, o0, e0, n0, bad;
    logic [AW-1:0] hold_d;
    logic [1:0]    hold_c;

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        ch_data = {$urandom, $urandom};
        cont = 4'hF;
        repeat (3) tick();
        chk("rst_ch_ready", 64'(ch_ready), 64'd0);
        chk("rst_eng_start", 64'(eng_start), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_eng_data", 64'(eng_data), 64'd0);
        chk("rst_eng_bank", 64'(eng_bank), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ch", 64'(out_ch), 64'd0);
        cont = '0;
        tick();
        rst = 1'b0;

        // Stale done straight after reset
        stale_req = 1;
        repeat (5) tick();
        chk("stale_out_valid", 64'(out_valid), 64'd0);
        chk("stale_no_grant", 64'(ready_pulses), 64'd0);

        // Single channel 1, fixed result, done 66 cycles after start
        ch_data = {$urandom, $urandom};
        ch_data[31:16] = 16'h0005;
        res_fix = 38'h123;
        res_fix_en = 1;
        eng_delay = 66;
        rp0 = ready_pulses;
        o0 = out_rises;
        pend = 4'b0010;
        for (int i = 0; i < 200 && out_rises == o0; i++) tick();
        chk("single_done", 64'(out_rises - o0), 64'd1);
        chk("single_out_data", 64'(out_data), 64'h123);
        chk("single_out_ch", 64'(out_ch), 64'd1);
        chk("single_bank", 64'(eng_bank), 64'd1);
        chk("single_ready_cnt", 64'(ready_pulses - rp0), 64'd1);
        chk("single_grant", 64'(grants[$]), 64'd1);
        res_fix_en = 0;
        repeat (3) tick();

        // All channels requesting continuously from a fresh pointer
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        eng_delay = 3;
        n0 = grants.size();
        cont = 4'hF;
        for (int i = 0; i < 400 && grants.size() < n0 + 12; i++) begin
            ch_data = {$urandom, $urandom};
            tick();
        end
        cont = '0;
        chk("rr_count", 64'(grants.size() >= n0 + 12), 64'd1);
        for (int k = 0; k < 12; k++) begin
            if (grants.size() > n0 + k)
                chk("rr_order", 64'(grants[n0+k]), 64'(k % N));
        end
        repeat (20) tick();

        // Engine never answers: timeout, then the next channel proceeds
        eng_delay = 0;
        e0 = err_pulses;
        o0 = out_rises;
        n0 = grants.size();
        pend = 4'b0101;
        for (int i = 0; i < 300 && err_pulses == e0; i++) tick();
        eng_delay = 5;
        chk("to_err", 64'(err_pulses - e0), 64'd1);
        for (int i = 0; i < 50 && out_rises == o0; i++) tick();
        chk("to_one_output", 64'(out_rises - o0), 64'd1);
        chk("to_first", 64'(grants[n0]), 64'd0);
        chk("to_next", 64'(grants[n0+1]), 64'd2);
        chk("to_next_ch", 64'(out_ch), 64'd2);
        repeat (10) tick();
        chk("to_single_pulse", 64'(err_pulses - e0), 64'd1);

        // Done on the very last BUSY cycle wins over the timeout
        eng_delay = 80;
        e0 = err_pulses;
        o0 = out_rises;
        pend = 4'b1000;
        for (int i = 0; i < 200 && out_rises == o0; i++) tick();
        chk("edge_delivered", 64'(out_rises - o0), 64'd1);
        chk("edge_no_err", 64'(err_pulses - e0), 64'd0);
        chk("edge_ch", 64'(out_ch), 64'd3);
        repeat (3) tick();

        // One cycle later it is a timeout and the late done is ignored
        eng_delay = 81;
        e0 = err_pulses;
        o0 = out_rises;
        pend = 4'b0001;
        for (int i = 0; i < 200 && err_pulses == e0; i++) tick();
        repeat (5) tick();
        chk("late_err", 64'(err_pulses - e0), 64'd1);
        chk("late_no_out", 64'(out_rises - o0), 64'd0);

        // Back-pressure: output held, nothing granted meanwhile
        eng_delay = 4;
        out_ready = 1'b0;
        pend = 4'b0010;
        for (int i = 0; i < 50 && out_valid !== 1'b1; i++) tick();
        chk("bp_valid", 64'(out_valid), 64'd1);
        hold_d = out_data;
        hold_c = out_ch;
        chk("bp_ch", 64'(hold_c), 64'd1);
        cont = 4'b0100;
        rp0 = ready_pulses;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            ch_data = {$urandom, $urandom};
            tick();
            if (out_valid !== 1'b1 || out_data !== hold_d ||
                out_ch !== hold_c || ch_ready !== '0) bad++;
        end
        chk("bp_stable", 64'(bad), 64'd0);
        chk("bp_no_grant", 64'(ready_pulses - rp0), 64'd0);
        chk_bubble = 1;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && ready_pulses == rp0; i++) tick();
        cont = '0;
        chk("bp_next_grant", 64'(grants[$]), 64'd2);
        repeat (15) tick();

        // Reset ten cycles into BUSY; the engine still answers later
        eng_delay = 15;
        e0 = err_pulses;
        o0 = out_rises;
        pend = 4'b0010;
        for (int i = 0; i < 20 && eng_start !== 1'b1; i++) tick();
        chk("mid_started", 64'(eng_start), 64'd1);
        repeat (11) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("mid_no_out", 64'(out_rises - o0), 64'd0);
        chk("mid_no_err", 64'(err_pulses - e0), 64'd0);
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        n0 = grants.size();
        pend = 4'hF;
        for (int i = 0; i < 20 && grants.size() == n0; i++) tick();
        pend = '0;
        chk("mid_ptr_reset", 64'(grants[n0]), 64'd0);
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
